rr_mux4_tx: RTL and testbench

//   Four-channel round-robin multiplexer/transmitter: merges four valid/ready

---
 rtl/rr_mux4_tx.sv | 67 ++++++
 tb/tb_rr_mux4_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux4_tx.sv
// Four-channel round-robin mux onto one registered data word plus 2-bit source select.
// Latency: 1 cycle from input accept to out_valid; one transfer per cycle sustained.
// Backpressure: while the output word is stalled (out_valid && !out_ready) in_ready is 0000 and all state holds.
module rr_mux4_tx #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_sel,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      out_count
);

    logic [1:0] ptr;
    logic [1:0] win_idx;
    logic       win_vld;
    logic       can_load;
    logic       load;
    logic       drain;

    assign can_load = !out_valid || out_ready;
    assign drain    = out_valid && out_ready;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (in_valid[ptr + 2'(i)]) begin
                win_vld = 1'b1;
                win_idx = ptr + 2'(i);
            end
        end
    end

    assign load     = win_vld && can_load;
    assign in_ready = (rst_n && load) ? (4'b0001 << win_idx) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
            out_count <= '0;
        end else begin
            if (load) begin
                out_data  <= in_data[win_idx*DATA_W +: DATA_W];
                out_sel   <= win_idx;
                out_valid <= 1'b1;
                ptr       <= win_idx + 2'd1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain) begin
                out_count <= out_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4_tx.sv
// Bench for rr_mux4_tx: directed scenarios plus random traffic against a
// transaction-level model of grants, held word and transfer count.
module tb_rr_mux4_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [0:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic [15:0] out_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_ptr = 0;
    int m_vld = 0;
    int m_dat = 0;
    int m_sel = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    rr_mux4_tx #(.DATA_W(1), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int grant(input logic [3:0] v);
        for (int j = 0; j < 4; j++) begin
            if (v[(m_ptr + j) % 4]) return (m_ptr + j) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_dat = 0; m_sel = 0; m_cnt = 0;
    endtask

    // Drive one cycle from the falling edge, check, clock it, advance the model.
    task automatic step(input logic [3:0] v, input logic [3:0] d, input logic r, input bit do_chk);
        int g;
        bit can;
        logic [3:0] er;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        g   = grant(v);
        can = (m_vld == 0) || r;
        er  = (can && g >= 0) ? (4'b0001 << g) : 4'b0000;
        if (do_chk) begin
            chk("in_ready",  in_ready,  er);
            chk("out_valid", out_valid, m_vld);
            chk("out_sel",   out_sel,   m_sel);
            chk("out_data",  out_data,  m_dat);
            chk("out_count", out_count, m_cnt);
        end
        @(posedge clk);
        if (m_vld != 0 && r) m_cnt = (m_cnt + 1) % 65536;
        if (can && g >= 0) begin
            m_dat = d[g];
            m_sel = g;
            m_vld = 1;
            m_ptr = (g + 1) % 4;
        end else if (m_vld != 0 && r) begin
            m_vld = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset is visible before any clock edge
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 4'b1111;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_sel",   out_sel,   0);
        chk("rst_count", out_count, 0);
        chk("rst_ready", in_ready,  0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single channel 2
        in_valid = 4'b0100; in_data = 4'b0100; #1;
        chk("single_ready", in_ready, 4'b0100);
        step(4'b0100, 4'b0100, 1'b1, 1);
        chk("single_valid", out_valid, 1);
        chk("single_sel",   out_sel,   2);
        chk("single_data",  out_data,  1);
        step(4'b0000, 4'b0000, 1'b1, 1);
        chk("single_count", out_count, 1);

        // Bring ptr back to 0, then all four valid for 8 cycles
        step(4'b1000, 4'b1000, 1'b1, 1);
        step(4'b0000, 4'b0000, 1'b1, 1);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'($urandom), 1'b1, 1);
            chk("rr_sel", out_sel, i % 4);
            chk("rr_valid", out_valid, 1);
        end
        step(4'b0000, 4'b0000, 1'b1, 1);
        chk("rr_count", out_count, 10);

        // Backpressure holding a channel-1 word
        step(4'b0010, 4'b0010, 1'b1, 1);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 4'b0000, 1'b0, 1);
            chk("stall_sel",  out_sel,  1);
            chk("stall_data", out_data, 1);
        end
        in_valid = 4'b1111; out_ready = 1'b1; #1;
        chk("stall_release_ready", in_ready, 4'b0100);
        step(4'b1111, 4'b0000, 1'b1, 1);
        chk("stall_next_sel", out_sel, 2);
        chk("stall_count", out_count, 11);
        step(4'b0000, 4'b0000, 1'b1, 1);

        // Pointer skip from ptr=1 with only channels 3 and 0 requesting
        step(4'b0001, 4'b0000, 1'b1, 1);
        step(4'b1001, 4'b1001, 1'b1, 1);
        chk("skip_first", out_sel, 3);
        step(4'b0001, 4'b0001, 1'b1, 1);
        chk("skip_second", out_sel, 0);
        in_valid = 4'b1111; #1;
        chk("skip_ptr", in_ready, 4'b0010);
        step(4'b0000, 4'b0000, 1'b1, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), 1);
        end

        // Preload the counter close to wrap, then cross it
        while (m_cnt != 65534) step(4'b1111, 4'($urandom), 1'b1, 0);
        step(4'b1111, 4'($urandom), 1'b1, 1);
        step(4'b1111, 4'($urandom), 1'b1, 1);
        chk("wrap_count", out_count, 0);
        chk("wrap_full",  out_valid, 1);

        // Asynchronous reset while full
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready,  0);
        chk("arst_count", out_count, 0);
        model_reset();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_hold_count", out_count, 0);
        chk("arst_hold_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 4'b0000, 1'b1, 1);
        step(4'b0000, 4'b0000, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
